// File: rtl/simon_encrypt_engine.sv
// Iterative SIMON encryption core: one Feistel round per clock, with the round key
// supplied combinationally by an external key scheduler indexed by round_idx.
module simon_encrypt_engine #(
  parameter int N      = 48,
  parameter int M      = 2,
  parameter int ROUNDS = 52
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   plaintext,
  input  logic [N*M-1:0]   key,
  output logic [N*M-1:0]   key_q,
  output logic [6:0]       round_idx,
  input  logic [N-1:0]     round_key,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   ciphertext,
  output logic             ct_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     x_q, x_d;
  logic [N-1:0]     y_q, y_d;
  logic [N*M-1:0]   key_d;
  logic [6:0]       round_idx_q, round_idx_d;
  logic [2*N-1:0]   ct_q, ct_d;
  logic             done_q, done_d;
  logic             ct_valid_q, ct_valid_d;
  logic [N-1:0]     x_new;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  assign x_new = y_q ^ (rotl(x_q, 1) & rotl(x_q, 8)) ^ rotl(x_q, 2) ^ round_key;

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    key_d       = key_q;
    round_idx_d = round_idx_q;
    ct_d        = ct_q;
    done_d      = 1'b0;
    ct_valid_d  = ct_valid_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d         = plaintext[2*N-1:N];
          y_d         = plaintext[N-1:0];
          key_d       = key;
          round_idx_d = '0;
          ct_valid_d  = 1'b0;
          state_d     = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        x_d = x_new;
        y_d = x_q;
        if (round_idx_q == LAST_IDX) begin
          // Capture {new x, new y}; new y is the pre-round x.
          ct_d       = {x_new, x_q};
          done_d     = 1'b1;
          ct_valid_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          round_idx_d = round_idx_q + 7'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: only flops here, so every register clears on reset; a run in flight is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      key_q       <= '0;
      round_idx_q <= '0;
      ct_q        <= '0;
      done_q      <= 1'b0;
      ct_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so x_q/y_q swap with the values from before the edge.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      key_q       <= key_d;
      round_idx_q <= round_idx_d;
      ct_q        <= ct_d;
      done_q      <= done_d;
      ct_valid_q  <= ct_valid_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign round_idx  = round_idx_q;
  assign ciphertext = ct_q;
  assign ct_valid   = ct_valid_q;

endmodule
